// File: rtl/scanner_buffer_unit.sv
// scanner_buffer_unit: fills a sample buffer while scanning, then drains it to the station over valid/ready.
module scanner_buffer_unit #(
  parameter int BUF_DEPTH   = 10,
  parameter int READY_LEVEL = 8,
  parameter int DATA_W      = 8,
  localparam int LW         = $clog2(BUF_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_scan,
  input  logic              go_transfer,
  input  logic              flush_req,
  input  logic              xfer_ready,
  output logic [1:0]        status,
  output logic [LW-1:0]     buffer_level,
  output logic              ready_to_transfer,
  output logic              xfer_valid,
  output logic [DATA_W-1:0] xfer_data,
  output logic              xfer_done
);
  typedef enum logic [1:0] {IDLE = 2'b00, SCAN = 2'b01, FULL = 2'b10, XFER = 2'b11} state_t;
  localparam logic [LW-1:0] RL = LW'(READY_LEVEL);
  localparam logic [LW-1:0] DEPTH = LW'(BUF_DEPTH);
  state_t state_q, state_d;
  logic [LW-1:0] level_q, level_d, ptr_q, ptr_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic rtt_q, rtt_d, valid_q, valid_d, done_q, done_d, wr;
  logic [DATA_W-1:0] mem_q [BUF_DEPTH];
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    wr      = 1'b0;
    case (state_q)
      IDLE: state_d = start_scan ? SCAN : IDLE;
      SCAN, FULL: begin
        if (flush_req) begin
          state_d = IDLE;
          level_d = '0;
          ptr_d   = '0;
        end else if (go_transfer && level_q >= RL) begin
          state_d = XFER;
          ptr_d   = '0;
        end else if (state_q == SCAN) begin
          wr      = 1'b1;
          level_d = level_q + 1'b1;
          cnt_d   = cnt_q + 1'b1;
          state_d = (level_d == DEPTH) ? FULL : SCAN;
        end
      end
      default: begin
        if (valid_q && xfer_ready) begin
          if (ptr_q == level_q - 1'b1) begin
            state_d = IDLE;
            level_d = '0;
            ptr_d   = '0;
            done_d  = 1'b1;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
    endcase
    rtt_d   = (state_d == SCAN || state_d == FULL) && level_d >= RL;
    valid_d = state_d == XFER;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      level_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      rtt_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      rtt_q   <= rtt_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end
  // RAM contents need no reset; xfer_data is gated so it reads 0 outside XFER
  always_ff @(posedge clk) begin
    if (wr) mem_q[level_q] <= cnt_q;
  end
  assign status            = state_q;
  assign buffer_level      = level_q;
  assign ready_to_transfer = rtt_q;
  assign xfer_valid        = valid_q;
  assign xfer_data         = valid_q ? mem_q[ptr_q] : '0;
  assign xfer_done         = done_q;
endmodule

// File: tb/tb_scanner_buffer_unit.sv
// tb_scanner_buffer_unit: directed scenarios plus random traffic against a queue-based behavioural model.
module tb_scanner_buffer_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic start_scan = 1'b0, go_transfer = 1'b0, flush_req = 1'b0, xfer_ready = 1'b0;
  logic [1:0] status;
  logic [3:0] buffer_level;
  logic ready_to_transfer, xfer_valid, xfer_done;
  logic [7:0] xfer_data;
  int errs = 0, checks = 0;
  int m_mode = 0, m_idx = 0, m_cnt = 0;
  bit m_done = 0;
  logic [7:0] mq[$];
  logic [7:0] beats[$];

  scanner_buffer_unit dut (
    .clk(clk), .rst(rst), .start_scan(start_scan), .go_transfer(go_transfer),
    .flush_req(flush_req), .xfer_ready(xfer_ready), .status(status),
    .buffer_level(buffer_level), .ready_to_transfer(ready_to_transfer),
    .xfer_valid(xfer_valid), .xfer_data(xfer_data), .xfer_done(xfer_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 scan, 2 full, 3 transfer; buffer is a queue, m_idx the next beat.
  task automatic step();
    if (rst) begin
      m_mode = 0; mq.delete(); m_idx = 0; m_cnt = 0; m_done = 0;
      return;
    end
    m_done = 0;
    case (m_mode)
      0: if (start_scan) m_mode = 1;
      1, 2: begin
        if (flush_req) begin
          m_mode = 0; mq.delete();
        end else if (go_transfer && mq.size() >= 8) begin
          m_mode = 3; m_idx = 0;
        end else if (m_mode == 1) begin
          mq.push_back(8'(m_cnt));
          m_cnt = (m_cnt + 1) % 256;
          if (mq.size() == 10) m_mode = 2;
        end
      end
      default: if (xfer_ready) begin
        m_idx++;
        if (m_idx == mq.size()) begin
          m_mode = 0; mq.delete(); m_idx = 0; m_done = 1;
        end
      end
    endcase
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    step();
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("status", int'(status), m_mode);
      chk("level", int'(buffer_level), mq.size());
      chk("ready_to_transfer", int'(ready_to_transfer), int'((m_mode == 1 || m_mode == 2) && mq.size() >= 8));
      chk("xfer_valid", int'(xfer_valid), int'(m_mode == 3));
      chk("xfer_done", int'(xfer_done), int'(m_done));
      if (m_mode == 3) chk("xfer_data", int'(xfer_data), int'(mq[m_idx]));
      if (xfer_valid && xfer_ready) beats.push_back(xfer_data);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    int k;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    chk("reset_status", int'(status), 0);
    chk("reset_level", int'(buffer_level), 0);
    // reset asserted mid-scan must clear outputs before any clock edge
    start_scan = 1'b1; cyc(1); start_scan = 1'b0;
    cyc(5);
    chk("t1_level5", int'(buffer_level), 5);
    #2 rst = 1'b1;
    #1;
    chk("t1_status", int'(status), 0);
    chk("t1_level", int'(buffer_level), 0);
    chk("t1_outs", int'({ready_to_transfer, xfer_valid, xfer_done, xfer_data}), 0);
    cyc(1);
    rst = 1'b0;
    cyc(1);
    // fill: go_transfer at level 5 is ignored
    start_scan = 1'b1; cyc(1); start_scan = 1'b0;
    chk("t2_scan", int'(status), 1);
    cyc(5);
    go_transfer = 1'b1; cyc(1); go_transfer = 1'b0;
    chk("t3_ignored_status", int'(status), 1);
    chk("t3_ignored_level", int'(buffer_level), 6);
    cyc(2);
    chk("t2_rtt", int'(ready_to_transfer), 1);
    chk("t2_level8", int'(buffer_level), 8);
    cyc(2);
    chk("t2_full", int'(status), 2);
    chk("t2_level10", int'(buffer_level), 10);
    cyc(20);
    chk("t2_hold_full", int'(status), 2);
    beats.delete();
    go_transfer = 1'b1; xfer_ready = 1'b1; cyc(1); go_transfer = 1'b0;
    chk("t3_xfer", int'(status), 3);
    cyc(10);
    chk("t3_done", int'(xfer_done), 1);
    chk("t3_idle", int'(status), 0);
    cyc(1);
    chk("t3_done_pulse", int'(xfer_done), 0);
    chk("t3_beats", beats.size(), 10);
    for (int i = 0; i < beats.size() && i < 10; i++) chk("t3_beat", int'(beats[i]), i);
    // stalled transfer
    beats.delete();
    start_scan = 1'b1; cyc(1); start_scan = 1'b0;
    cyc(10);
    go_transfer = 1'b1;
    for (int i = 0; i < 60; i++) begin
      xfer_ready = (i % 3 == 0);
      cyc(1);
      go_transfer = 1'b0;
      if (status == 2'b00) break;
    end
    chk("t4_beats", beats.size(), 10);
    for (int i = 0; i < beats.size() && i < 10; i++) chk("t4_beat", int'(beats[i]), 10 + i);
    // flush beats go_transfer; sample counter survives the flush
    xfer_ready = 1'b1;
    start_scan = 1'b1; cyc(1); start_scan = 1'b0;
    cyc(9);
    chk("t5_level9", int'(buffer_level), 9);
    flush_req = 1'b1; go_transfer = 1'b1; cyc(1); flush_req = 1'b0; go_transfer = 1'b0;
    chk("t5_status", int'(status), 0);
    chk("t5_level", int'(buffer_level), 0);
    chk("t5_valid", int'(xfer_valid), 0);
    beats.delete();
    start_scan = 1'b1; cyc(1); start_scan = 1'b0;
    cyc(10);
    go_transfer = 1'b1; cyc(1); go_transfer = 1'b0;
    cyc(10);
    chk("t5_beats", beats.size(), 10);
    if (beats.size() > 0) chk("t5_first", int'(beats[0]), 29);
    // back-to-back scans with start_scan held; data wraps past 255
    beats.delete();
    start_scan = 1'b1;
    for (int i = 0; i < 1500 && beats.size() < 260; i++) begin
      go_transfer = (status == 2'b10);
      cyc(1);
    end
    start_scan = 1'b0; go_transfer = 1'b0;
    chk("t6_bound", int'(beats.size() >= 260), 1);
    for (int i = 0; i < beats.size() && i < 260; i++) chk("t6_beat", int'(beats[i]), (39 + i) % 256);
    // random traffic, occasional async reset
    for (int i = 0; i < 3000; i++) begin
      k = $urandom_range(0, 499);
      start_scan  = ($urandom_range(0, 3) == 0);
      go_transfer = ($urandom_range(0, 5) == 0);
      flush_req   = ($urandom_range(0, 19) == 0);
      xfer_ready  = $urandom_range(0, 1);
      if (k == 0) rst = 1'b1;
      cyc(1);
      rst = 1'b0;
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
